// File: rtl/wallace_tree.sv
// 16x16 unsigned multiplier: Wallace carry-save tree (16->11->8->6->4->3->2 rows), final
// carry-propagate adder, and a two-deep history of captured products.
module wallace_tree (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        ClearA_LoadB,
  input  logic [15:0] MUR,
  input  logic [15:0] MUD,
  output logic [31:0] z1,
  output logic [31:0] z2,
  output logic [31:0] result,
  output logic [31:0] result1,
  output logic [31:0] result2
);

  function automatic logic [31:0] csa_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    return a ^ b ^ c;
  endfunction

  // Carry row is pre-shifted to its true weight; bit 31 falls off and is always 0 here.
  function automatic logic [31:0] csa_carry(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [31:0] w_l0 [16];
  logic [31:0] w_l1 [11];
  logic [31:0] w_l2 [8];
  logic [31:0] w_l3 [6];
  logic [31:0] w_l4 [4];
  logic [31:0] w_l5 [3];
  logic [31:0] w_l6 [2];

  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign w_l0[i] = {16'b0, MUD & {16{MUR[i]}}} << i;
  end

  // Level 1: 16 -> 11
  for (genvar g = 0; g < 5; g++) begin : g_l1
    assign w_l1[2*g]   = csa_sum  (w_l0[3*g], w_l0[3*g+1], w_l0[3*g+2]);
    assign w_l1[2*g+1] = csa_carry(w_l0[3*g], w_l0[3*g+1], w_l0[3*g+2]);
  end
  assign w_l1[10] = w_l0[15];

  // Level 2: 11 -> 8
  for (genvar g = 0; g < 3; g++) begin : g_l2
    assign w_l2[2*g]   = csa_sum  (w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
    assign w_l2[2*g+1] = csa_carry(w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
  end
  assign w_l2[6] = w_l1[9];
  assign w_l2[7] = w_l1[10];

  // Level 3: 8 -> 6
  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign w_l3[2*g]   = csa_sum  (w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
    assign w_l3[2*g+1] = csa_carry(w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
  end
  assign w_l3[4] = w_l2[6];
  assign w_l3[5] = w_l2[7];

  // Level 4: 6 -> 4
  for (genvar g = 0; g < 2; g++) begin : g_l4
    assign w_l4[2*g]   = csa_sum  (w_l3[3*g], w_l3[3*g+1], w_l3[3*g+2]);
    assign w_l4[2*g+1] = csa_carry(w_l3[3*g], w_l3[3*g+1], w_l3[3*g+2]);
  end

  // Level 5: 4 -> 3, level 6: 3 -> 2
  assign w_l5[0] = csa_sum  (w_l4[0], w_l4[1], w_l4[2]);
  assign w_l5[1] = csa_carry(w_l4[0], w_l4[1], w_l4[2]);
  assign w_l5[2] = w_l4[3];

  assign w_l6[0] = csa_sum  (w_l5[0], w_l5[1], w_l5[2]);
  assign w_l6[1] = csa_carry(w_l5[0], w_l5[1], w_l5[2]);

  assign z1     = w_l6[0];
  assign z2     = w_l6[1];
  assign result = w_l6[0] + w_l6[1];

  logic [31:0] r_result1;
  logic [31:0] r_result2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_result1 <= '0;
      r_result2 <= '0;
    end else if (ClearA_LoadB) begin
      r_result1 <= '0;
      r_result2 <= '0;
    end else if (Run) begin
      r_result2 <= r_result1;
      r_result1 <= result;
    end
  end

  assign result1 = r_result1;
  assign result2 = r_result2;

endmodule

// File: tb/tb_wallace_tree.sv
// Self-checking bench for wallace_tree: directed and random products, history, clear, reset.
module tb_wallace_tree;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic        ClearA_LoadB;
  logic [15:0] MUR;
  logic [15:0] MUD;
  logic [31:0] z1;
  logic [31:0] z2;
  logic [31:0] result;
  logic [31:0] result1;
  logic [31:0] result2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference history: products captured since the last clear, newest at the back.
  logic [31:0] hist_q[$];

  wallace_tree dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .MUR          (MUR),
    .MUD          (MUD),
    .z1           (z1),
    .z2           (z2),
    .result       (result),
    .result1      (result1),
    .result2      (result2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic logic [31:0] exp_r1();
    return (hist_q.size() >= 1) ? hist_q[hist_q.size()-1] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_r2();
    return (hist_q.size() >= 2) ? hist_q[hist_q.size()-2] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [31:0] zs;
    MUR = a;
    MUD = b;
    #1;
    zs = z1 + z2;
    check({tag, " result"}, result, ref_prod(a, b));
    check({tag, " z1+z2"}, zs, ref_prod(a, b));
  endtask

  task automatic check_hist(input string tag);
    check({tag, " result1"}, result1, exp_r1());
    check({tag, " result2"}, result2, exp_r2());
  endtask

  task automatic apply_edge(input logic run, input logic clr, input string tag);
    @(negedge Clk);
    Run          = run;
    ClearA_LoadB = clr;
    if (clr) hist_q.delete();
    else if (run) begin
      hist_q.push_back(ref_prod(MUR, MUD));
      if (hist_q.size() > 2) void'(hist_q.pop_front());
    end
    @(posedge Clk);
    #1;
    check_hist(tag);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
  endtask

  initial begin
    Reset        = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    MUR          = '0;
    MUD          = '0;
    #2;
    check("reset result1", result1, 32'h0);
    check("reset result2", result2, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    set_ops(16'h3333, 16'h0030, "basic");
    check("basic const", result, 32'h0009_9990);
    set_ops(16'hFFFF, 16'hFFFF, "max");
    check("max const", result, 32'hFFFE_0001);
    set_ops(16'h0000, 16'hABCD, "zero");
    check("zero const", result, 32'h0);
    set_ops(16'h0001, 16'hABCD, "one");
    check("one const", result, 32'h0000_ABCD);
    set_ops(16'h8000, 16'h8000, "msb");

    for (int i = 0; i < 10000; i++) begin
      set_ops(16'($urandom), 16'($urandom), "rand");
    end

    set_ops(16'h0002, 16'h0003, "hist a");
    apply_edge(1'b1, 1'b0, "hist cap1");
    set_ops(16'h0010, 16'h0010, "hist b");
    apply_edge(1'b1, 1'b0, "hist cap2");
    check("hist result1 const", result1, 32'h0000_0100);
    check("hist result2 const", result2, 32'h0000_0006);
    set_ops(16'h0123, 16'h0456, "hist hold ops");
    apply_edge(1'b0, 1'b0, "hist hold");

    apply_edge(1'b1, 1'b1, "clr prio");
    check("clr result1 const", result1, 32'h0);
    set_ops(16'h0007, 16'h0009, "post clr");
    apply_edge(1'b1, 1'b0, "post clr cap");
    check("post clr const", result1, 32'h0000_003F);

    set_ops(16'h1234, 16'h5678, "arst ops");
    apply_edge(1'b1, 1'b0, "arst load");
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    hist_q.delete();
    check("arst result1", result1, 32'h0);
    check("arst result2", result2, 32'h0);
    set_ops(16'hAAAA, 16'h5555, "arst track");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_hist("arst release");

    for (int i = 0; i < 300; i++) begin
      MUR = 16'($urandom);
      MUD = 16'($urandom);
      apply_edge(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "rand hist");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
